// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multicycle controller.
//   - opcode / funct field values the decoder recognises
//   - ALUcntrl, ALUSrcB, PCSrc and err_code encodings
//   - FSM state enum and decoded instruction class enum
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_RS  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JUMP, S_JR, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_LW, CLS_SW, CLS_R, CLS_I, CLS_BEQ, CLS_BNE, CLS_J, CLS_JR, CLS_ILL
  } cls_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the controller and the datapath/memory.
//   inputs to controller : op, funct, zero, mem_ready
//   outputs of controller: datapath strobes/selects, retire, halted, err_code
//   master = controller side, slave = datapath side
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       PCWr, IRWr, IorD, MemRd, MemWr, RegDst, RegWr, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUcntrl;
  logic       retire;
  logic       halted;
  logic [1:0] err_code;

  modport master (
    input  op, funct, zero, mem_ready,
    output PCWr, IRWr, IorD, MemRd, MemWr, RegDst, RegWr, MemToReg, ALUSrcA,
           ALUSrcB, PCSrc, ALUcntrl, retire, halted, err_code
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  PCWr, IRWr, IorD, MemRd, MemWr, RegDst, RegWr, MemToReg, ALUSrcA,
           ALUSrcB, PCSrc, ALUcntrl, retire, halted, err_code
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational instruction decoder.
//   op_i, funct_i : instruction fields
//   cls_o         : instruction class driving the FSM dispatch
//   alu_o         : ALU operation for R-type / immediate instructions
//   zext_o        : immediate is zero-extended (xori) rather than sign-extended
//   illegal_o     : instruction not supported in this configuration
// With EXT_OPS = 0 the and/or/addi/beq encodings fall through to illegal.
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [2:0] alu_o,
  output logic       zext_o,
  output logic       illegal_o
);

  localparam bit EXT = (EXT_OPS != 0);

  always_comb begin
    cls_o  = CLS_ILL;
    alu_o  = ALU_ADD;
    zext_o = 1'b0;
    case (op_i)
      OP_LW: cls_o = CLS_LW;
      OP_SW: cls_o = CLS_SW;
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD: begin cls_o = CLS_R; alu_o = ALU_ADD; end
          FN_SUB: begin cls_o = CLS_R; alu_o = ALU_SUB; end
          FN_SLT: begin cls_o = CLS_R; alu_o = ALU_SLT; end
          FN_AND: if (EXT) begin cls_o = CLS_R; alu_o = ALU_AND; end
          FN_OR:  if (EXT) begin cls_o = CLS_R; alu_o = ALU_OR;  end
          FN_JR:  cls_o = CLS_JR;
          default: ;
        endcase
      end
      OP_XORI: begin cls_o = CLS_I; alu_o = ALU_XOR; zext_o = 1'b1; end
      OP_ADDI: if (EXT) begin cls_o = CLS_I; alu_o = ALU_ADD; end
      OP_BEQ:  if (EXT) cls_o = CLS_BEQ;
      OP_BNE:  cls_o = CLS_BNE;
      OP_J:    cls_o = CLS_J;
      default: ;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle CPU controller.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : mc_ctrl_if.master (instruction fields, zero flag,
//                mem_ready in; datapath strobes, retire, halted, err_code out)
//
// state    | meaning
// ---------+-----------------------------------------------------
// FETCH    | read instruction, latch IR and PC+4 on mem_ready
// DECODE   | classify instruction, precompute branch target
// MEMADR   | compute load/store address
// MEMRD    | load data read, wait for mem_ready
// MEMWB    | write loaded data to register file
// MEMWR    | store data write, retire on mem_ready
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// ALUWB    | write ALU result to register file
// BRANCH   | compare, conditionally load branch target
// JUMP     | load jump target
// JR       | load PC from rs
// TRAP     | halted on illegal instruction or memory timeout
//
// Strobes come from the registered state; FETCH IRWr/PCWr, MEMWR retire and
// BRANCH PCWr additionally follow mem_ready/zero in the same cycle. All
// outputs are forced to 0 while reset is high, even before the reset edge.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned EXT_OPS     = 1
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_e     state_q;
  cls_e       cls_q;
  logic [2:0] alu_q;
  logic       zext_q;
  logic [1:0] err_q;
  logic [7:0] wait_q, wait_d;

  cls_e       dec_cls;
  logic [2:0] dec_alu;
  logic       dec_zext;
  logic       dec_illegal;

  logic       mem_wait;
  logic       timeout;
  logic [1:0] imm_srcb;

  mc_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .op_i      (bus.op),
    .funct_i   (bus.funct),
    .cls_o     (dec_cls),
    .alu_o     (dec_alu),
    .zext_o    (dec_zext),
    .illegal_o (dec_illegal)
  );

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // mem_ready on the terminal cycle wins over the timeout.
  assign timeout  = mem_wait && !bus.mem_ready && (wait_q == TMO);
  // Counter is zero whenever a wait state is entered, since it clears on
  // every cycle that is not an unfinished wait.
  assign wait_d   = (mem_wait && !bus.mem_ready && !timeout) ? wait_q + 8'd1 : 8'd0;
  assign imm_srcb = zext_q ? SRCB_ZEXT : SRCB_SEXT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_ILL;
      alu_q   <= ALU_ADD;
      zext_q  <= 1'b0;
      err_q   <= ERR_NONE;
      wait_q  <= 8'd0;
    end else begin
      wait_q <= wait_d;
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready) begin
            state_q <= S_DECODE;
          end else if (timeout) begin
            state_q <= S_TRAP;
            err_q   <= ERR_TIMEOUT;
          end
        end
        S_DECODE: begin
          cls_q  <= dec_cls;
          alu_q  <= dec_alu;
          zext_q <= dec_zext;
          if (dec_illegal) begin
            state_q <= S_TRAP;
            err_q   <= ERR_ILLEGAL;
          end else begin
            case (dec_cls)
              CLS_LW, CLS_SW:   state_q <= S_MEMADR;
              CLS_R:            state_q <= S_EXEC_R;
              CLS_I:            state_q <= S_EXEC_I;
              CLS_BEQ, CLS_BNE: state_q <= S_BRANCH;
              CLS_J:            state_q <= S_JUMP;
              CLS_JR:           state_q <= S_JR;
              default: begin
                state_q <= S_TRAP;
                err_q   <= ERR_ILLEGAL;
              end
            endcase
          end
        end
        S_MEMADR: state_q <= (cls_q == CLS_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD, S_MEMWR: begin
          if (bus.mem_ready) begin
            state_q <= (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
          end else if (timeout) begin
            state_q <= S_TRAP;
            err_q   <= ERR_TIMEOUT;
          end
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JR: state_q <= S_FETCH;
        S_TRAP: state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.PCWr     = 1'b0;
    bus.IRWr     = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRd    = 1'b0;
    bus.MemWr    = 1'b0;
    bus.RegDst   = 1'b0;
    bus.RegWr    = 1'b0;
    bus.MemToReg = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_REG;
    bus.PCSrc    = PCSRC_ALU;
    bus.ALUcntrl = ALU_ADD;
    bus.retire   = 1'b0;
    bus.halted   = 1'b0;
    bus.err_code = ERR_NONE;
    if (!reset) begin
      bus.err_code = err_q;
      case (state_q)
        S_FETCH: begin
          bus.MemRd   = 1'b1;
          bus.ALUSrcB = SRCB_FOUR;
          bus.IRWr    = bus.mem_ready;
          bus.PCWr    = bus.mem_ready;
        end
        S_DECODE: bus.ALUSrcB = SRCB_SEXT;
        S_MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_SEXT;
        end
        S_MEMRD: begin
          bus.MemRd = 1'b1;
          bus.IorD  = 1'b1;
        end
        S_MEMWB: begin
          bus.RegWr    = 1'b1;
          bus.MemToReg = 1'b1;
          bus.retire   = 1'b1;
        end
        S_MEMWR: begin
          bus.MemWr  = 1'b1;
          bus.IorD   = 1'b1;
          bus.retire = bus.mem_ready;
        end
        S_EXEC_R: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUSrcB  = SRCB_REG;
          bus.ALUcntrl = alu_q;
        end
        S_EXEC_I: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUSrcB  = imm_srcb;
          bus.ALUcntrl = alu_q;
        end
        S_ALUWB: begin
          bus.RegWr    = 1'b1;
          bus.retire   = 1'b1;
          bus.RegDst   = (cls_q == CLS_R);
          bus.ALUSrcA  = 1'b1;
          bus.ALUSrcB  = (cls_q == CLS_R) ? SRCB_REG : imm_srcb;
          bus.ALUcntrl = alu_q;
        end
        S_BRANCH: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUSrcB  = SRCB_REG;
          bus.ALUcntrl = ALU_SUB;
          bus.PCSrc    = PCSRC_BR;
          bus.PCWr     = (cls_q == CLS_BEQ) ? bus.zero : !bus.zero;
          bus.retire   = 1'b1;
        end
        S_JUMP: begin
          bus.PCSrc  = PCSRC_JMP;
          bus.PCWr   = 1'b1;
          bus.retire = 1'b1;
        end
        S_JR: begin
          bus.PCSrc  = PCSRC_RS;
          bus.PCWr   = 1'b1;
          bus.retire = 1'b1;
        end
        S_TRAP: bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl.
// Two instances share the input pins: dut_a (MEM_TIMEOUT=15, EXT_OPS=1) and
// dut_b (MEM_TIMEOUT=3, EXT_OPS=0). One is exercised while the other is held
// in reset. For each instruction a per-cycle expected waveform is generated
// from the instruction class and the chosen memory wait counts.
module tb_mc_ctrl;

  localparam logic [19:0] M_PCWR   = 20'h80000;
  localparam logic [19:0] M_IRWR   = 20'h40000;
  localparam logic [19:0] M_IORD   = 20'h20000;
  localparam logic [19:0] M_MEMRD  = 20'h10000;
  localparam logic [19:0] M_MEMWR  = 20'h08000;
  localparam logic [19:0] M_REGDST = 20'h04000;
  localparam logic [19:0] M_REGWR  = 20'h02000;
  localparam logic [19:0] M_M2R    = 20'h01000;
  localparam logic [19:0] M_SRCA   = 20'h00800;
  localparam logic [19:0] M_RET    = 20'h00008;
  localparam logic [19:0] M_HALT   = 20'h00004;

  typedef struct packed {
    logic [19:0] exp;
    logic        rdy;
    logic        z;
    logic        real_op;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [5:0] op, funct;
  logic       zero, mem_ready;

  int checks;
  int errors;

  step_t      q[$];
  logic [5:0] cur_op, cur_f;
  bit         expect_trap;

  mc_ctrl_if if_a ();
  mc_ctrl_if if_b ();

  assign if_a.op = op;
  assign if_a.funct = funct;
  assign if_a.zero = zero;
  assign if_a.mem_ready = mem_ready;
  assign if_b.op = op;
  assign if_b.funct = funct;
  assign if_b.zero = zero;
  assign if_b.mem_ready = mem_ready;

  mc_ctrl #(.MEM_TIMEOUT(15), .EXT_OPS(1)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a.master));
  mc_ctrl #(.MEM_TIMEOUT(3),  .EXT_OPS(0)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b.master));

  wire [19:0] out_a = {if_a.PCWr, if_a.IRWr, if_a.IorD, if_a.MemRd, if_a.MemWr, if_a.RegDst,
                       if_a.RegWr, if_a.MemToReg, if_a.ALUSrcA, if_a.ALUSrcB, if_a.PCSrc,
                       if_a.ALUcntrl, if_a.retire, if_a.halted, if_a.err_code};
  wire [19:0] out_b = {if_b.PCWr, if_b.IRWr, if_b.IorD, if_b.MemRd, if_b.MemWr, if_b.RegDst,
                       if_b.RegWr, if_b.MemToReg, if_b.ALUSrcA, if_b.ALUSrcB, if_b.PCSrc,
                       if_b.ALUcntrl, if_b.retire, if_b.halted, if_b.err_code};

  function automatic logic [19:0] sb(input logic [1:0] v);
    return {9'b0, v, 9'b0};
  endfunction
  function automatic logic [19:0] pc(input logic [1:0] v);
    return {11'b0, v, 7'b0};
  endfunction
  function automatic logic [19:0] al(input logic [2:0] v);
    return {13'b0, v, 4'b0};
  endfunction
  function automatic logic [19:0] er(input logic [1:0] v);
    return {18'b0, v};
  endfunction

  // rm/zm: 0 or 1 drives that value, 2 drives a random value (don't-care cycle)
  function automatic void push(input logic [19:0] e, input int rm, input int zm, input bit real_op);
    step_t s;
    s.exp     = e;
    s.rdy     = (rm == 2) ? 1'($urandom) : (rm == 1);
    s.z       = (zm == 2) ? 1'($urandom) : (zm == 1);
    s.real_op = real_op;
    q.push_back(s);
  endfunction

  function automatic void push_trap(input logic [1:0] err);
    push(M_HALT | er(err), 2, 2, 1'b1);
    push(M_HALT | er(err), 2, 2, 1'b1);
    expect_trap = 1'b1;
  endfunction

  // A wait state survives t low cycles of mem_ready; the (t+1)-th low cycle traps.
  function automatic bit mem_phase(input logic [19:0] base, input int t, input int w, input bit ret_on_rdy);
    if (w > t) begin
      for (int i = 0; i <= t; i++) push(base, 0, 2, 1'b1);
      push_trap(2'b10);
      return 1'b1;
    end
    for (int i = 0; i < w; i++) push(base, 0, 2, 1'b1);
    push(base | (ret_on_rdy ? M_RET : 20'h0), 1, 2, 1'b1);
    return 1'b0;
  endfunction

  function automatic void build(input int sel, input logic [5:0] o, input logic [5:0] f,
                                input logic zb, input int wf, input int wm);
    int t;
    bit ext;
    int k;
    logic [2:0] alu;
    logic [1:0] isb;
    t = (sel != 0) ? 3 : 15;
    ext = (sel == 0);
    q.delete();
    cur_op = o;
    cur_f = f;
    expect_trap = 1'b0;
    k = 0;
    alu = 3'b000;
    isb = 2'b10;
    if (wf > t) begin
      for (int i = 0; i <= t; i++) push(M_MEMRD | sb(2'b01), 0, 2, 1'b0);
      push_trap(2'b10);
      return;
    end
    for (int i = 0; i < wf; i++) push(M_MEMRD | sb(2'b01), 0, 2, 1'b0);
    push(M_MEMRD | sb(2'b01) | M_IRWR | M_PCWR, 1, 2, 1'b0);
    push(sb(2'b10), 2, 2, 1'b1);
    // classes: 0 illegal, 1 lw, 2 sw, 3 R-type alu, 4 xori, 5 addi, 6 beq, 7 bne, 8 j, 9 jr
    case (o)
      6'b100011: k = 1;
      6'b101011: k = 2;
      6'b000000: begin
        case (f)
          6'b100000: begin k = 3; alu = 3'b000; end
          6'b100010: begin k = 3; alu = 3'b010; end
          6'b101010: begin k = 3; alu = 3'b011; end
          6'b100100: if (ext) begin k = 3; alu = 3'b100; end
          6'b100101: if (ext) begin k = 3; alu = 3'b101; end
          6'b001000: k = 9;
          default: k = 0;
        endcase
      end
      6'b001110: begin k = 4; alu = 3'b001; isb = 2'b11; end
      6'b001000: if (ext) begin k = 5; alu = 3'b000; isb = 2'b10; end
      6'b000100: if (ext) k = 6;
      6'b000101: k = 7;
      6'b000010: k = 8;
      default: k = 0;
    endcase
    case (k)
      1: begin
        push(M_SRCA | sb(2'b10), 2, 2, 1'b1);
        if (!mem_phase(M_MEMRD | M_IORD, t, wm, 1'b0)) push(M_REGWR | M_M2R | M_RET, 2, 2, 1'b1);
      end
      2: begin
        push(M_SRCA | sb(2'b10), 2, 2, 1'b1);
        void'(mem_phase(M_MEMWR | M_IORD, t, wm, 1'b1));
      end
      3: begin
        push(M_SRCA | sb(2'b00) | al(alu), 2, 2, 1'b1);
        push(M_REGWR | M_REGDST | M_RET | M_SRCA | sb(2'b00) | al(alu), 2, 2, 1'b1);
      end
      4, 5: begin
        push(M_SRCA | sb(isb) | al(alu), 2, 2, 1'b1);
        push(M_REGWR | M_RET | M_SRCA | sb(isb) | al(alu), 2, 2, 1'b1);
      end
      6, 7: begin
        push(M_SRCA | sb(2'b00) | al(3'b010) | pc(2'b01) | M_RET |
             (((k == 6 && zb) || (k == 7 && !zb)) ? M_PCWR : 20'h0), 2, zb ? 1 : 0, 1'b1);
      end
      8: push(M_PCWR | M_RET | pc(2'b10), 2, 2, 1'b1);
      9: push(M_PCWR | M_RET | pc(2'b11), 2, 2, 1'b1);
      default: push_trap(2'b01);
    endcase
  endfunction

  task automatic check(input int sel, input logic [19:0] exp, input string tag, input int idx);
    logic [19:0] act;
    logic [19:0] idle;
    act  = (sel != 0) ? out_b : out_a;
    idle = (sel != 0) ? out_a : out_b;
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d op=%b funct=%b cyc=%0d observed=%05h expected=%05h",
             tag, sel, cur_op, cur_f, idx, act, exp);
    end
    checks++;
    assert (idle === 20'h0) else begin
      errors++;
      $error("FAIL idle_in_reset dut=%0d cyc=%0d observed=%05h expected=00000", 1 - sel, idx, idle);
    end
  endtask

  task automatic do_reset(input int sel);
    if (sel != 0) rst_b = 1'b1; else rst_a = 1'b1;
    mem_ready = 1'($urandom);
    zero = 1'($urandom);
    op = 6'($urandom);
    funct = 6'($urandom);
    @(negedge clk);
    check(sel, 20'h0, "reset", -1);
    @(posedge clk);
    #1;
    if (sel != 0) rst_b = 1'b0; else rst_a = 1'b0;
  endtask

  // Runs the queued waveform starting in FETCH; abort >= 0 asserts reset on that cycle.
  task automatic run(input int sel, input int abort);
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort) begin
        do_reset(sel);
        return;
      end
      mem_ready = q[i].rdy;
      zero = q[i].z;
      if (q[i].real_op) begin
        op = cur_op;
        funct = cur_f;
      end else begin
        op = 6'($urandom);
        funct = 6'($urandom);
      end
      @(negedge clk);
      check(sel, q[i].exp, "step", i);
      @(posedge clk);
      #1;
    end
    if (expect_trap) do_reset(sel);
  endtask

  task automatic pick(output logic [5:0] o, output logic [5:0] f);
    logic [5:0] fl [6];
    fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b101010;
    fl[3] = 6'b100100; fl[4] = 6'b100101; fl[5] = 6'b001000;
    f = 6'($urandom);
    case ($urandom_range(0, 9))
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: begin o = 6'b000000; f = fl[$urandom_range(0, 5)]; end
      3: o = 6'b001110;
      4: o = 6'b001000;
      5: o = 6'b000100;
      6: o = 6'b000101;
      7: o = 6'b000010;
      8: begin o = 6'b000000; f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b001000; end
      default: o = 6'($urandom);
    endcase
  endtask

  function automatic int rw(input int t);
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return t + 1;
    if (r == 1) return t;
    return int'($urandom_range(0, 2));
  endfunction

  initial begin
    logic [5:0] o, f;
    int ab;
    checks = 0;
    errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(0);

    // dut_a directed: add, lw with two wait cycles, bne both ways, the rest of the set
    build(0, 6'b000000, 6'b100000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b100011, 6'b010101, 1'b0, 0, 2); run(0, -1);
    build(0, 6'b000101, 6'b000000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b000101, 6'b000000, 1'b1, 0, 0); run(0, -1);
    build(0, 6'b000100, 6'b000000, 1'b1, 1, 0); run(0, -1);
    build(0, 6'b000100, 6'b000000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b101011, 6'b111111, 1'b0, 1, 0); run(0, -1);
    build(0, 6'b001110, 6'b000000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b001000, 6'b000000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b000000, 6'b100100, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b000000, 6'b100101, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b000000, 6'b101010, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b000000, 6'b100010, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b000010, 6'b000000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b000000, 6'b001000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b111111, 6'b000000, 1'b0, 0, 0); run(0, -1);
    build(0, 6'b101011, 6'b000000, 1'b0, 0, 15); run(0, -1);
    build(0, 6'b100011, 6'b000000, 1'b0, 16, 0); run(0, -1);
    build(0, 6'b100011, 6'b000000, 1'b0, 0, 16); run(0, -1);
    build(0, 6'b100011, 6'b000000, 1'b0, 0, 3); run(0, 4);

    for (int n = 0; n < 120; n++) begin
      pick(o, f);
      build(0, o, f, 1'($urandom), rw(15), rw(15));
      ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      run(0, ab);
    end

    // switch to dut_b: reduced instruction set, short memory timeout
    rst_a = 1'b1;
    do_reset(1);
    build(1, 6'b000100, 6'b000000, 1'b0, 0, 0); run(1, -1);
    build(1, 6'b000010, 6'b000000, 1'b0, 4, 0); run(1, -1);
    build(1, 6'b000010, 6'b000000, 1'b0, 3, 0); run(1, -1);
    build(1, 6'b000000, 6'b100000, 1'b0, 0, 0); run(1, -1);
    build(1, 6'b000000, 6'b100100, 1'b0, 0, 0); run(1, -1);
    build(1, 6'b001000, 6'b000000, 1'b0, 0, 0); run(1, -1);
    build(1, 6'b100011, 6'b000000, 1'b0, 0, 4); run(1, -1);
    build(1, 6'b101011, 6'b000000, 1'b0, 0, 3); run(1, -1);
    build(1, 6'b101011, 6'b000000, 1'b0, 0, 4); run(1, -1);

    for (int n = 0; n < 120; n++) begin
      pick(o, f);
      build(1, o, f, 1'($urandom), rw(3), rw(3));
      ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      run(1, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
